// File: rtl/alu_serial_ctrl_if.sv
// Bundle between the serial ALU controller, its requester and the 1-bit ALU slice.
// The requester (master) issues operations and reads back results; the controller
// (slave) also drives the slice and reads back the slice's combinational outputs.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    // Request side
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       cfg_op;
    logic             cfg_sm;
    logic             cfg_sa;
    logic             cfg_sb;
    logic             cfg_cin;

    // Status / result side
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;

    // 1-bit ALU slice drive and return
    logic             alu_a;
    logic             alu_b;
    logic             alu_cin;
    logic             alu_sm;
    logic             alu_sa;
    logic             alu_sb;
    logic [1:0]       alu_op;
    logic             alu_result;
    logic             alu_cout;

    modport slave (
        input  start, abort, op_a, op_b, cfg_op, cfg_sm, cfg_sa, cfg_sb, cfg_cin,
        input  alu_result, alu_cout,
        output busy, done, result, c_out,
        output alu_a, alu_b, alu_cin, alu_sm, alu_sa, alu_sb, alu_op
    );

    modport master (
        output start, abort, op_a, op_b, cfg_op, cfg_sm, cfg_sa, cfg_sb, cfg_cin,
        output alu_result, alu_cout,
        input  busy, done, result, c_out,
        input  alu_a, alu_b, alu_cin, alu_sm, alu_sa, alu_sb, alu_op
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: feeds WIDTH operand bit pairs LSB first through an
// external 1-bit ALU slice, chaining the carry, and assembles the result word.
// The result register is only written when an operation completes, so an aborted
// operation leaves the previous result and carry-out visible.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sm_q, sm_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;

    logic             run;

    assign run = (state_q == S_RUN);

    // Next-state logic: accept in IDLE, shift one bit per RUN cycle, publish on the last bit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sm_d    = sm_q;
        sa_d    = sa_q;
        sb_d    = sb_q;

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here, so start always wins
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    op_d    = bus.cfg_op;
                    sm_d    = bus.cfg_sm;
                    sa_d    = bus.cfg_sa;
                    sb_d    = bus.cfg_sb;
                    carry_d = bus.cfg_cin;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    // Drop the partial word; result/c_out keep the last completed op
                    state_d = S_IDLE;
                end else begin
                    sh_d    = {bus.alu_result, sh_q[WIDTH-1:1]};
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    carry_d = bus.alu_cout;
                    if (cnt_q == CNT_LAST) begin
                        res_d   = {bus.alu_result, sh_q[WIDTH-1:1]};
                        cout_d  = bus.alu_cout;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            sm_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sm_q    <= sm_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    // Slice data inputs are live only in RUN; op/mode selects always show the latched config
    assign bus.alu_a   = run & a_q[0];
    assign bus.alu_b   = run & b_q[0];
    assign bus.alu_cin = run & carry_q;
    assign bus.alu_op  = op_q;
    assign bus.alu_sm  = sm_q;
    assign bus.alu_sa  = sa_q;
    assign bus.alu_sb  = sb_q;

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = res_q;
    assign bus.c_out   = cout_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl with an adder-style 1-bit slice (sum = a^b^cin,
// carry = majority). A transaction-level model predicts every output each cycle
// from whole-word arithmetic; directed tests add hand-computed literal checks.
module tb_alu_serial_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Slice model
    assign bus.alu_result = bus.alu_a ^ bus.alu_b ^ bus.alu_cin;
    assign bus.alu_cout   = (bus.alu_a & bus.alu_b) | (bus.alu_a & bus.alu_cin) | (bus.alu_b & bus.alu_cin);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: cycles left in the busy window (W RUN cycles + 1 DONE cycle)
    int     m_left;
    longint m_a, m_b, m_cin, m_sum;
    longint m_op, m_sm, m_sa, m_sb;
    longint m_res, m_cout;
    bit     cmp_en;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_a = 0; m_b = 0; m_cin = 0; m_sum = 0;
        m_op = 0; m_sm = 0; m_sa = 0; m_sb = 0; m_res = 0; m_cout = 0;
    endtask

    task automatic model_step();
        if (m_left == 0) begin
            if (bus.start) begin
                m_a = longint'(bus.op_a); m_b = longint'(bus.op_b); m_cin = longint'(bus.cfg_cin);
                m_op = longint'(bus.cfg_op); m_sm = longint'(bus.cfg_sm);
                m_sa = longint'(bus.cfg_sa); m_sb = longint'(bus.cfg_sb);
                m_sum  = m_a + m_b + m_cin;
                m_left = W + 1;
            end
        end else if (bus.abort && m_left > 1) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_res  = m_sum & ((64'sd1 <<< W) - 1);
                m_cout = (m_sum >>> W) & 1;
            end
        end
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                int     k;
                longint mask, exp_a, exp_b, exp_c;
                exp_a = 0; exp_b = 0; exp_c = 0;
                if (m_left >= 2) begin
                    k     = W + 1 - m_left;
                    mask  = (64'sd1 <<< k) - 1;
                    exp_a = (m_a >>> k) & 1;
                    exp_b = (m_b >>> k) & 1;
                    exp_c = (((m_a & mask) + (m_b & mask) + m_cin) >>> k) & 1;
                end
                chk("busy",    longint'(bus.busy),    longint'(m_left > 0));
                chk("done",    longint'(bus.done),    longint'(m_left == 1));
                chk("result",  longint'(bus.result),  m_res);
                chk("c_out",   longint'(bus.c_out),   m_cout);
                chk("alu_a",   longint'(bus.alu_a),   exp_a);
                chk("alu_b",   longint'(bus.alu_b),   exp_b);
                chk("alu_cin", longint'(bus.alu_cin), exp_c);
                chk("alu_op",  longint'(bus.alu_op),  m_op);
                chk("alu_sm",  longint'(bus.alu_sm),  m_sm);
                chk("alu_sa",  longint'(bus.alu_sa),  m_sa);
                chk("alu_sb",  longint'(bus.alu_sb),  m_sb);
            end
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [1:0] op, input logic sm, input logic sa, input logic sb);
        bus.op_a = a; bus.op_b = b; bus.cfg_cin = cin;
        bus.cfg_op = op; bus.cfg_sm = sm; bus.cfg_sa = sa; bus.cfg_sb = sb;
    endtask

    // Called just after a negedge in IDLE; returns at the negedge of RUN cycle 0
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // i0 = negedges already seen since the accepting edge; lat counts the same way
    task automatic wait_done(input int i0, output int lat, output int busy_n);
        lat    = -1;
        busy_n = bus.busy ? 1 : 0;
        for (int i = i0 + 1; i <= i0 + 40 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) lat = i;
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) c++;
        end
    endtask

    initial begin
        int lat, bn, nd, d0, d1;
        checks = 0; errors = 0; cmp_en = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        set_ops('0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        model_reset();
        fork
            model_loop();
            compare_loop();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_busy",   longint'(bus.busy),   0);
        chk("rst_done",   longint'(bus.done),   0);
        chk("rst_result", longint'(bus.result), 0);
        chk("rst_cout",   longint'(bus.c_out),  0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 0x35 + 0x1C: latency 9 negedges, busy for 9 cycles
        set_ops(8'h35, 8'h1C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, lat, bn);
        chk("A_latency", lat, 9);
        chk("A_busy_cycles", bn, 9);
        chk("A_result", longint'(bus.result), 64'h51);
        chk("A_cout", longint'(bus.c_out), 0);
        @(negedge clk);
        chk("A_busy_after", longint'(bus.busy), 0);

        // Carry ripples through every bit
        set_ops(8'hFF, 8'h01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, lat, bn);
        chk("B1_result", longint'(bus.result), 64'h00);
        chk("B1_cout", longint'(bus.c_out), 1);
        @(negedge clk);
        // Initial carry only
        set_ops(8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, lat, bn);
        chk("B2_result", longint'(bus.result), 64'h01);
        chk("B2_cout", longint'(bus.c_out), 0);
        @(negedge clk);

        // Config held through RUN; start pulsed mid-RUN is ignored
        set_ops(8'h12, 8'h34, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("C_alu_op", longint'(bus.alu_op), 2);
        chk("C_alu_sb", longint'(bus.alu_sb), 1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(5, lat, bn);
        chk("C_latency", lat, 9);
        chk("C_result", longint'(bus.result), 64'h46);
        count_dones(15, nd);
        chk("C_extra_dones", nd, 0);

        // Abort in RUN cycle 4 keeps the previous result
        set_ops(8'h35, 8'h1C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_done(1, lat, bn);
        chk("D_result_pre", longint'(bus.result), 64'h51);
        @(negedge clk);
        set_ops(8'hAA, 8'h55, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_start();
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("D_busy_after_abort", longint'(bus.busy), 0);
        count_dones(15, nd);
        chk("D_dones", nd, 0);
        chk("D_result_kept", longint'(bus.result), 64'h51);
        chk("D_cout_kept", longint'(bus.c_out), 0);

        // start held high for 20 cycles: two operations, dones 10 cycles apart
        set_ops(8'h80, 8'h80, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        nd = 0; d0 = -1; d1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (nd == 0) d0 = i; else d1 = i;
                nd++;
            end
        end
        bus.start = 1'b0;
        chk("E_dones", nd, 2);
        chk("E_first_done", d0, 9);
        chk("E_gap", d1 - d0, 10);
        chk("E_result", longint'(bus.result), 64'h00);
        chk("E_cout", longint'(bus.c_out), 1);
        repeat (3) @(negedge clk);

        // Reset mid-RUN clears everything at once and leaves no pending done
        set_ops(8'h35, 8'h1C, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
        pulse_start();
        wait_done(1, lat, bn);
        chk("F_result_pre", longint'(bus.result), 64'h51);
        @(negedge clk);
        pulse_start();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("F_rst_busy",   longint'(bus.busy),   0);
        chk("F_rst_done",   longint'(bus.done),   0);
        chk("F_rst_result", longint'(bus.result), 0);
        chk("F_rst_cout",   longint'(bus.c_out),  0);
        chk("F_rst_alu_op", longint'(bus.alu_op), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        count_dones(15, nd);
        chk("F_dones_after_rst", nd, 0);
        chk("F_busy_after_rst", longint'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 op_a, op_b  input  WIDTH each  operands, latched on accepted start.
REQ-007 cfg_op  input  2  slice op code, latched on accepted start.
REQ-008 cfg_sm, cfg_sa, cfg_sb, cfg_cin  input  1 each  slice mode/invert selects and initial carry, latched on accepted start.
REQ-009 alu_a, alu_b, alu_cin, alu_sm, alu_sa, alu_sb  output  1 each  drive to the 1-bit ALU slice.
REQ-010 alu_op  output  2  drive to the slice op input.
REQ-011 alu_result, alu_cout  input  1 each  slice outputs, combinational from the alu_* drives.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse; result and c_out valid.
REQ-014 result  output  WIDTH  assembled result word.
REQ-015 c_out  output  1  carry out of the MSB slice step.

Function
REQ-016 FSM SHALL have states IDLE, RUN, DONE.
REQ-017 IDLE: start=1 at an edge SHALL latch op_a, op_b, cfg_*; load carry register with cfg_cin; clear bit counter; enter RUN.
REQ-018 RUN: alu_a = a shift reg bit 0, alu_b = b shift reg bit 0, alu_cin = carry register, alu_op/alu_sm/alu_sa/alu_sb = latched config, constant for whole operation.
REQ-019 RUN each edge: shift alu_result into result register at MSB (right shift, LSB first), shift a/b registers right, carry register <= alu_cout, counter +1.
REQ-020 RUN SHALL last exactly WIDTH cycles; edge on which counter = WIDTH-1 SHALL transition to DONE.
REQ-021 DONE lasts one cycle with done=1; c_out = carry register (last bit's alu_cout); next state IDLE.
REQ-022 Latency: start sampled at edge N -> done high in cycle after edge N+WIDTH.
REQ-023 result and c_out SHALL hold their values in IDLE until the next accepted start; they are not cleared by start.
REQ-024 start while busy SHALL be ignored (not queued).
REQ-025 start held high continuously SHALL be accepted again on the first edge in IDLE after DONE (back-to-back: one idle cycle between operations).
REQ-026 abort=1 in RUN SHALL return to IDLE at that edge, no done pulse, result/c_out left unchanged from the previous completed operation (result shift writes suppressed: use a separate shift register, copy to result only on entering DONE).
REQ-027 abort in IDLE or DONE SHALL have no effect; abort and start same edge in IDLE: start wins.
REQ-028 alu_* outputs in IDLE and DONE SHALL be 0, except alu_op/mode selects which hold latched config.
REQ-029 Counter width SHALL be ceil(log2(WIDTH)) bits; no wrap beyond WIDTH-1.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, c_out=0, carry register=0, counter=0, all alu_* outputs and latched config=0.
REQ-031 Reset asserted mid-RUN SHALL discard the operation; after release, no done until a new start.

Verification
(Bench slice model: alu_result = alu_a^alu_b^alu_cin, alu_cout = majority(alu_a,alu_b,alu_cin); WIDTH=8.)
REQ-032 op_a=8'h35, op_b=8'h1C, cfg_cin=0, start one cycle -> done 9 cycles later (after edge N+8), result=8'h51, c_out=0, busy high 9 cycles.
REQ-033 op_a=8'hFF, op_b=8'h01, cfg_cin=0 -> result=8'h00, c_out=1; then op_a=8'h00, op_b=8'h00, cfg_cin=1 -> result=8'h01, c_out=0.
REQ-034 cfg_op=2'b10, cfg_sb=1: alu_op=2'b10 and alu_sb=1 constant every RUN cycle; start pulsed again in RUN cycle 3 -> ignored, exactly one done.
REQ-035 Complete op (result=8'h51), start new op, abort in RUN cycle 4 -> no done, busy low next cycle, result stays 8'h51.
REQ-036 start held high 20 cycles -> done pulses separated by exactly 10 cycles; rst_n low mid-RUN -> busy=0, result=0 asynchronously, no done after release.
